// File: rtl/inst_fetch_if.sv
// Instruction fetch bus: memory read port, decode handoff, redirect and halt.
// master is the fetch unit, slave is the memory/decoder environment.
interface inst_fetch_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] inop;
    logic [15:0] inop_pc;
    logic        inop_valid;
    logic        inop_ready;
    logic        br_taken;
    logic [15:0] br_target;
    logic        halt;

    modport master (
        output mem_req, mem_addr, inop, inop_pc, inop_valid,
        input  mem_ack, mem_rdata, inop_ready, br_taken, br_target, halt
    );

    modport slave (
        input  mem_req, mem_addr, inop, inop_pc, inop_valid,
        output mem_ack, mem_rdata, inop_ready, br_taken, br_target, halt
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: one outstanding read, 2-entry {pc,instr} buffer,
// branch redirect with drain of an in-flight request.
module inst_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input logic          clk,
    input logic          rst,
    inst_fetch_if.master bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] drain_q, drain_d;
    logic [15:0] fpc_q [2];
    logic [15:0] fins_q [2];
    logic        rd_q, wr_q;
    logic [1:0]  cnt_q, cnt_d;
    logic        ack, push, pop, go;

    assign ack  = (state_q != IDLE) && bus.mem_ack;
    assign push = (state_q == FETCH) && bus.mem_ack && !bus.br_taken;
    assign pop  = (cnt_q != 2'd0) && bus.inop_ready && !bus.br_taken;

    assign cnt_d = cnt_q - {1'b0, pop} + {1'b0, push};
    // Only request when the returning word is guaranteed a free slot.
    assign go    = (cnt_d < 2'd2) && !bus.halt && !bus.br_taken;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drain_d = drain_q;
        unique case (state_q)
            IDLE: begin
                if (go) state_d = FETCH;
            end
            FETCH: begin
                if (bus.br_taken) begin
                    state_d = ack ? IDLE : DRAIN;
                    drain_d = pc_q;
                end else if (ack) begin
                    state_d = go ? FETCH : IDLE;
                end
            end
            DRAIN: begin
                if (ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (push)         pc_d = pc_q + 16'd1;
        if (bus.br_taken) pc_d = bus.br_target;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            drain_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drain_q <= drain_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= 2'd0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            fpc_q[0]  <= 16'h0000;
            fpc_q[1]  <= 16'h0000;
            fins_q[0] <= 16'h0000;
            fins_q[1] <= 16'h0000;
        end else if (bus.br_taken) begin
            cnt_q <= 2'd0;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
        end else begin
            if (push) begin
                fpc_q[wr_q]  <= pc_q;
                fins_q[wr_q] <= bus.mem_rdata;
                wr_q         <= ~wr_q;
            end
            if (pop) rd_q <= ~rd_q;
            cnt_q <= cnt_d;
        end
    end

    assign bus.mem_req    = (state_q != IDLE);
    assign bus.mem_addr   = (state_q == DRAIN) ? drain_q : pc_q;
    assign bus.inop_valid = (cnt_q != 2'd0);
    assign bus.inop       = fins_q[rd_q];
    assign bus.inop_pc    = fpc_q[rd_q];

endmodule

// File: tb/tb_inst_fetch.sv
// Random-stimulus bench for inst_fetch against a queue-based fetch model,
// plus a second instance checking address wrap from RESET_PC=FFFE.
module tb_inst_fetch;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    inst_fetch_if bus ();
    inst_fetch_if b2 ();

    inst_fetch #(.RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    inst_fetch #(.RESET_PC(16'hFFFE)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2.master)
    );

    assign b2.mem_ack    = 1'b1;
    assign b2.inop_ready = 1'b1;
    assign b2.br_taken   = 1'b0;
    assign b2.br_target  = 16'h0000;
    assign b2.halt       = 1'b0;
    assign b2.mem_rdata  = ~b2.mem_addr;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: buffered entries, next fetch address, in-flight request.
    logic [31:0] q[$];
    logic [15:0] m_pc;
    logic [15:0] m_req_addr;
    bit          m_out;
    bit          m_disc;

    task automatic model_reset();
        q.delete();
        m_pc       = 16'h0000;
        m_req_addr = 16'h0000;
        m_out      = 1'b0;
        m_disc     = 1'b0;
    endtask

    task automatic check_outputs();
        chk("mem_req", {15'd0, bus.mem_req}, {15'd0, m_out});
        chk("mem_addr", bus.mem_addr, m_out ? m_req_addr : m_pc);
        chk("inop_valid", {15'd0, bus.inop_valid}, {15'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("inop", bus.inop, q[0][15:0]);
            chk("inop_pc", bus.inop_pc, q[0][31:16]);
        end
    endtask

    task automatic model_step(input bit ack, input bit rdy, input bit br,
                              input logic [15:0] tgt, input bit hlt,
                              input logic [15:0] rdata);
        bit ackd;
        ackd = m_out && ack;
        if (q.size() != 0 && rdy && !br) void'(q.pop_front());
        if (ackd && !m_disc && !br) begin
            q.push_back({m_req_addr, rdata});
            m_pc = m_req_addr + 16'd1;
        end
        if (br) begin
            q.delete();
            m_pc = tgt;
        end
        if (m_out) begin
            if (ackd) begin
                if (m_disc || br) begin
                    m_out  = 1'b0;
                    m_disc = 1'b0;
                end else if (q.size() < 2 && !hlt) begin
                    m_req_addr = m_pc;
                end else begin
                    m_out = 1'b0;
                end
            end else if (br) begin
                m_disc = 1'b1;
            end
        end else if (!br && !hlt && q.size() < 2) begin
            m_out      = 1'b1;
            m_req_addr = m_pc;
        end
    endtask

    initial begin
        bit          ack, rdy, br, hlt;
        logic [15:0] tgt, rdata, e2;

        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = 16'h0000;
        bus.inop_ready = 1'b0;
        bus.br_taken   = 1'b0;
        bus.br_target  = 16'h0000;
        bus.halt       = 1'b0;
        model_reset();

        @(negedge clk);
        @(negedge clk);
        chk("rst_inop", bus.inop, 16'h0000);
        chk("rst_inop_pc", bus.inop_pc, 16'h0000);
        chk("rst2_addr", b2.mem_addr, 16'hFFFE);
        rst = 1'b1;

        for (int i = 0; i < 2000; i++) begin
            if (i == 70 || i == 700 || i == 1400) begin
                rst = 1'b0;
                #1;
                chk("rst_req", {15'd0, bus.mem_req}, 16'd0);
                chk("rst_addr", bus.mem_addr, 16'h0000);
                chk("rst_valid", {15'd0, bus.inop_valid}, 16'd0);
                chk("rst_inop", bus.inop, 16'h0000);
                chk("rst_inop_pc", bus.inop_pc, 16'h0000);
                model_reset();
                @(posedge clk);
                @(negedge clk);
                rst = 1'b1;
            end

            check_outputs();
            if (i >= 1 && i <= 3) begin
                e2 = 16'hFFFE + 16'(i - 1);
                chk("wrap_addr", b2.mem_addr, e2);
            end
            if (i >= 2 && i <= 4) begin
                e2 = 16'hFFFE + 16'(i - 2);
                chk("wrap_inop_pc", b2.inop_pc, e2);
                chk("wrap_inop", b2.inop, ~e2);
            end

            if (i < 20) begin
                ack = 1'b1; rdy = 1'b1; br = 1'b0; hlt = 1'b0;
            end else if (i < 40) begin
                ack = 1'b1; rdy = 1'b0; br = 1'b0; hlt = 1'b0;
            end else begin
                ack = ($urandom_range(0, 2) != 0);
                rdy = ($urandom_range(0, 1) != 0);
                br  = ($urandom_range(0, 9) == 0);
                hlt = ($urandom_range(0, 7) == 0);
            end
            tgt   = 16'($urandom);
            rdata = 16'($urandom);
            bus.mem_ack    = ack;
            bus.inop_ready = rdy;
            bus.br_taken   = br;
            bus.br_target  = tgt;
            bus.halt       = hlt;
            bus.mem_rdata  = rdata;

            @(posedge clk);
            model_step(ack, rdy, br, tgt, hlt, rdata);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
